// File: rtl/pattern_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pattern_stream_pkg
// Shared types and default sizes for the pattern stream controller slice.
//   ctrl_state_e : sequencer states (also exported on the debug state port)
//   DEF_*        : default parameter values used by the top and its interface
// -----------------------------------------------------------------------------
package pattern_stream_pkg;

    localparam int DEF_WORD_W  = 8;
    localparam int DEF_PAT_MAX = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pattern_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// pattern_stream_ctrl_if
// Word input port of the pattern stream controller.
//   in_valid : source has a word on in_data/in_last
//   in_ready : controller can take a word this cycle
//   in_data  : word, serialised MSB first
//   in_last  : word is the final one of the run
// Handshake: a word transfers on every rising clk edge where in_valid and
// in_ready are both 1. Once raised, the source holds in_valid, in_data and
// in_last stable until that transfer; in_ready may change freely and the
// source must not wait for in_ready before raising in_valid.
// -----------------------------------------------------------------------------
interface pattern_stream_ctrl_if #(
    parameter int WORD_W = pattern_stream_pkg::DEF_WORD_W
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/pattern_shift_matcher.sv
// -----------------------------------------------------------------------------
// pattern_shift_matcher
// Bit history shift register with a masked compare against a pattern.
//   clk, resetn : clock, synchronous active-low reset
//   shift_en    : shift bit_in into the history this cycle
//   clr         : clear history and bits-seen counter (wins over shift_en)
//   bit_in      : serial bit, newest
//   pattern     : pattern, bit 0 = most recent bit
//   len         : active length (already limited to PAT_MAX), 0 = no match
//   match       : combinational; 1 when the shift happening this cycle
//                 completes a match (compare looks at the post-shift history)
// -----------------------------------------------------------------------------
module pattern_shift_matcher #(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match
);

    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [PAT_MAX-1:0] hist_shift;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   seen_q, seen_d;
    logic [LEN_W-1:0]   seen_inc;

    always_comb begin
        hist_shift = {hist_q[PAT_MAX-2:0], bit_in};
        // bits_seen saturates at PAT_MAX; it only gates the compare
        seen_inc   = (seen_q == LEN_W'(PAT_MAX)) ? seen_q : seen_q + 1'b1;

        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (LEN_W'(i) < len) mask[i] = 1'b1;
        end

        hist_d = hist_q;
        seen_d = seen_q;
        if (clr) begin
            hist_d = '0;
            seen_d = '0;
        end else if (shift_en) begin
            hist_d = hist_shift;
            seen_d = seen_inc;
        end

        // Evaluated on the history as it will be after this shift so the
        // registered pulse lands one cycle after the completing shift.
        match = shift_en && !clr && (len != '0) && (seen_inc >= len) &&
                (((hist_shift ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/pattern_stream_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_stream_ctrl
// Accepts words, serialises them MSB first into a programmable overlapping
// pattern matcher, counts matches and raises a sticky threshold interrupt.
//   clk, resetn  : clock, synchronous active-low reset
//   cfg_we       : latch cfg_pattern/cfg_len/cfg_thresh (ignored while busy)
//   cfg_pattern  : pattern, bit 0 = most recent bit
//   cfg_len      : pattern length, 0 disables, >PAT_MAX treated as PAT_MAX
//   cfg_thresh   : irq threshold, 0 disables irq
//   start        : begin a run (ignored while busy)
//   in_if        : word input port (valid/ready, see interface)
//   busy         : run in progress
//   match_pulse  : one-cycle pulse per match
//   match_count  : matches since start, saturating
//   irq          : sticky, match_count >= cfg_thresh, cleared by start
//   done         : one-cycle pulse at end of run
//   state_dbg    : current sequencer state
// -----------------------------------------------------------------------------
module pattern_stream_ctrl
    import pattern_stream_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_we,
    input  logic [PAT_MAX-1:0]   cfg_pattern,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [CNT_W-1:0]     cfg_thresh,
    input  logic                 start,
    pattern_stream_ctrl_if.slave in_if,
    output logic                 busy,
    output logic                 match_pulse,
    output logic [CNT_W-1:0]     match_count,
    output logic                 irq,
    output logic                 done,
    output ctrl_state_e          state_dbg
);

    localparam int              IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    ctrl_state_e        state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               last_q, last_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic               pulse_q, pulse_d;
    logic               shift_en;
    logic               clr;
    logic               match;

    pattern_shift_matcher #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .resetn   (resetn),
        .shift_en (shift_en),
        .clr      (clr),
        .bit_in   (word_q[WORD_W-1]),
        .pattern  (pat_q),
        .len      (len_q),
        .match    (match)
    );

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        last_d   = last_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        len_d    = len_q;
        thresh_d = thresh_q;
        count_d  = count_q;
        irq_d    = irq_q;
        shift_en = 1'b0;
        clr      = 1'b0;

        if (cfg_we && (state_q == IDLE)) begin
            pat_d    = cfg_pattern;
            len_d    = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
            thresh_d = cfg_thresh;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    clr     = 1'b1;
                    count_d = '0;
                    irq_d   = 1'b0;
                end
            end
            WAIT: begin
                if (in_if.in_valid) begin
                    word_d  = in_if.in_data;
                    last_d  = in_if.in_last;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // word_q is shifted left so its MSB is always the next bit out
                shift_en = 1'b1;
                word_d   = {word_q[WORD_W-2:0], 1'b0};
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = last_q ? DONE : WAIT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (match && (count_q != '1)) count_d = count_q + 1'b1;

        // Count only moves during SHIFT, so irq follows the new count there;
        // the threshold cannot change mid-run because config writes need IDLE.
        if ((state_q == SHIFT) && (thresh_q != '0) && (count_d >= thresh_q)) irq_d = 1'b1;

        pulse_d = match;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            word_q   <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            thresh_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            thresh_q <= thresh_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            pulse_q  <= pulse_d;
        end
    end

    assign in_if.in_ready = (state_q == WAIT);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign match_pulse    = pulse_q;
    assign match_count    = count_q;
    assign irq            = irq_q;
    assign state_dbg      = state_q;

endmodule
